alu_share_arbiter: RTL and testbench

- Shares one combinational 16-bit ALU (operand A/B, 3-bit opcode, carry-in; result, zero and negative flags) between two requesters.
- Each requester issues an operation through a valid/ready handshake and receives the result through a response valid/ready handshake.
- The block arbitrates round-robin, registers operands toward the ALU, waits a programmable settle time, captures result and flags, and holds them until the owner accepts.
- Sits between client FSMs (datapath controllers) and the shared ALU instance.

---
 rtl/alu_share_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 15 +
 rtl/alu_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and defaults for the two-requester ALU sharing block.
package alu_share_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int OPC_W_DEF = 3;
    localparam int CNT_W     = 4;   // settle counter, SETTLE up to 15

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_RESP
    } state_t;

    // One operation as presented to the ALU
    typedef struct packed {
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        logic [OPC_W_DEF-1:0] opc;
        logic                 c;
    } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: pointer breaks ties, single requester always wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o,
    output logic       gidx_o
);

    // Select winner index and one-hot grant
    always_comb begin
        gidx_o  = (valid_i == 2'b11) ? ptr_i : valid_i[1];
        grant_o = (|valid_i) ? (2'b01 << gidx_o) : 2'b00;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates one combinational ALU between two requesters: grant, drive
// registered operands, wait SETTLE cycles, capture result/flags, hold
// until the owner accepts.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int OPC_W  = OPC_W_DEF,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [2*OPC_W-1:0]   req_opc,
    input  logic [1:0]           req_c,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_w,
    output logic                 rsp_zer,
    output logic                 rsp_neg,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [OPC_W-1:0]     alu_opc,
    output logic                 alu_c,
    input  logic [WIDTH-1:0]     alu_w,
    input  logic                 alu_zer,
    input  logic                 alu_neg,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] SETTLE_L = CNT_W'(SETTLE);

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic                 owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    alu_req_t             alu_q, alu_d;
    logic [WIDTH-1:0]     rsp_w_q, rsp_w_d;
    logic                 rsp_zer_q, rsp_zer_d;
    logic                 rsp_neg_q, rsp_neg_d;

    alu_req_t             req_s [2];
    logic [1:0]           grant;
    logic                 gidx;

    // Unpack per-requester payload slices into request structs
    for (genvar i = 0; i < 2; i++) begin : g_req
        assign req_s[i] = '{a:   req_a[i*WIDTH +: WIDTH],
                            b:   req_b[i*WIDTH +: WIDTH],
                            opc: req_opc[i*OPC_W +: OPC_W],
                            c:   req_c[i]};
    end

    rr_arb2 u_arb (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .gidx_o  (gidx)
    );

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            alu_q     <= '0;
            rsp_w_q   <= '0;
            rsp_zer_q <= 1'b0;
            rsp_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            alu_q     <= alu_d;
            rsp_w_q   <= rsp_w_d;
            rsp_zer_q <= rsp_zer_d;
            rsp_neg_q <= rsp_neg_d;
        end
    end

    // Next-state and register updates per FSM state
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        alu_d     = alu_q;
        rsp_w_d   = rsp_w_q;
        rsp_zer_d = rsp_zer_q;
        rsp_neg_d = rsp_neg_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    alu_d   = req_s[gidx];
                    owner_d = gidx;
                    cnt_d   = SETTLE_L;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_w_d   = alu_w;
                    rsp_zer_d = alu_zer;
                    rsp_neg_d = alu_neg;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                // Only the owner's accept counts; the other line is ignored
                if (rsp_ready[owner_q]) begin
                    ptr_d   = ~owner_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; request accept is masked while reset is held
    always_comb begin
        req_ready = (state_q == S_IDLE && rst_n) ? grant : 2'b00;
        rsp_valid = (state_q == S_RESP) ? (2'b01 << owner_q) : 2'b00;
        busy      = (state_q != S_IDLE);
        alu_a     = alu_q.a;
        alu_b     = alu_q.b;
        alu_opc   = alu_q.opc;
        alu_c     = alu_q.c;
        rsp_w     = rsp_w_q;
        rsp_zer   = rsp_zer_q;
        rsp_neg   = rsp_neg_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU.
module tb_alu_share_arbiter;

    localparam int W = 16;
    localparam int O = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid, req_ready, req_c;
    logic [2*W-1:0] req_a, req_b;
    logic [2*O-1:0] req_opc;
    logic [1:0]     rsp_valid, rsp_ready;
    logic [W-1:0]   rsp_w, alu_a, alu_b, alu_w;
    logic           rsp_zer, rsp_neg, alu_c, alu_zer, alu_neg, busy;
    logic [O-1:0]   alu_opc;

    int errs   = 0;
    int checks = 0;

    alu_share_arbiter #(.WIDTH(W), .OPC_W(O), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opc(req_opc), .req_c(req_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_w(rsp_w), .rsp_zer(rsp_zer), .rsp_neg(rsp_neg),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opc(alu_opc), .alu_c(alu_c),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU shared by both requesters
    always_comb begin
        case (alu_opc)
            3'd0:    alu_w = alu_a + alu_b + {15'b0, alu_c};
            3'd1:    alu_w = alu_a - alu_b;
            3'd2:    alu_w = alu_a & alu_b;
            3'd3:    alu_w = alu_a | alu_b;
            3'd4:    alu_w = alu_a ^ alu_b;
            default: alu_w = alu_a;
        endcase
    end
    assign alu_zer = (alu_w == '0);
    assign alu_neg = alu_w[W-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant must never be both lines at once
    always @(negedge clk) chk("req_ready_onehot", 32'(req_ready != 2'b11), 32'd1);

    task automatic drive_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [O-1:0] opc, input logic c);
        req_a[i*W +: W]   = a;
        req_b[i*W +: W]   = b;
        req_opc[i*O +: O] = opc;
        req_c[i]          = c;
        req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Full single-requester operation with latency and hold checks
    task automatic do_op(input string tag, input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [O-1:0] opc, input logic c,
                         input logic [W-1:0] ew, input logic ez, input logic en);
        logic [1:0] oh;
        oh = 2'b01 << i;
        drive_req(i, a, b, opc, c);
        #1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(oh));
        tick();
        req_valid[i] = 1'b0;
        chk({tag, "_alu_a"}, 32'(alu_a), 32'(a));
        chk({tag, "_alu_b"}, 32'(alu_b), 32'(b));
        chk({tag, "_alu_opc"}, 32'(alu_opc), 32'(opc));
        chk({tag, "_alu_c"}, 32'(alu_c), 32'(c));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rsp_early1"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "_rsp_early2"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
        chk({tag, "_rsp_w"}, 32'(rsp_w), 32'(ew));
        chk({tag, "_rsp_zer"}, 32'(rsp_zer), 32'(ez));
        chk({tag, "_rsp_neg"}, 32'(rsp_neg), 32'(en));
        tick();
        chk({tag, "_rsp_hold"}, 32'(rsp_valid), 32'(oh));
        rsp_ready = oh;
        tick();
        rsp_ready = 2'b00;
        chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] oh;
        int n;
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_opc = '0; req_c = '0;

        // Reset with both requesters pending
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_rsp_w", 32'(rsp_w), 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        tick();

        // Single op, then flag cases (pointer alternates but single valid always wins)
        do_op("single", 0, 16'h0005, 16'h0003, 3'd0, 1'b0, 16'h0008, 1'b0, 1'b0);
        do_op("zero",   1, 16'h0005, 16'h0005, 3'd1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("neg",    0, 16'h8000, 16'h0001, 3'd0, 1'b0, 16'h8001, 1'b0, 1'b1);
        do_op("carry",  1, 16'h00F0, 16'h000F, 3'd0, 1'b1, 16'h0100, 1'b0, 1'b0);

        // Tie from reset: grants alternate 0,1,0,1
        do_reset();
        drive_req(0, 16'd1, 16'd2, 3'd0, 1'b0);    // 3
        drive_req(1, 16'd10, 16'd4, 3'd1, 1'b0);   // 6
        for (int k = 0; k < 4; k++) begin
            oh = 2'b01 << (k % 2);
            #1;
            chk("tie_grant", 32'(req_ready), 32'(oh));
            tick();
            n = 0;
            while (rsp_valid == 2'b00 && n < 20) begin tick(); n++; end
            chk("tie_rsp_timeout", 32'(n < 20), 32'd1);
            chk("tie_rsp_valid", 32'(rsp_valid), 32'(oh));
            chk("tie_rsp_w", 32'(rsp_w), (k % 2) ? 32'd6 : 32'd3);
            rsp_ready = oh;
            tick();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
        tick();

        // Backpressure: owner 0 stalls, requester 1 waits, non-owner accept ignored
        do_reset();
        drive_req(0, 16'h0007, 16'h0002, 3'd2, 1'b0);  // 7 & 2 = 2
        #1;
        chk("bp_grant0", 32'(req_ready), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        drive_req(1, 16'h0003, 16'h0003, 3'd0, 1'b1);  // 7
        tick();
        tick();
        rsp_ready = 2'b10;
        for (int k = 0; k < 10; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_w", 32'(rsp_w), 32'd2);
            chk("bp_alu_a", 32'(alu_a), 32'd7);
            chk("bp_alu_b", 32'(alu_b), 32'd2);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("bp_grant1", 32'(req_ready), 32'd2);
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        chk("bp_rsp1_valid", 32'(rsp_valid), 32'd2);
        chk("bp_rsp1_w", 32'(rsp_w), 32'd7);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;

        // Reset mid-op: pointer is 1 before reset and must return to 0
        do_op("pre", 0, 16'h0001, 16'h0001, 3'd0, 1'b0, 16'h0002, 1'b0, 1'b0);
        drive_req(1, 16'h0001, 16'h0001, 3'd0, 1'b0);
        #1;
        chk("mid_grant1", 32'(req_ready), 32'd2);
        tick();
        req_valid[1] = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
            chk("mid_idle", 32'(busy), 32'd0);
        end
        drive_req(0, 16'd20, 16'd22, 3'd0, 1'b0);  // 42
        drive_req(1, 16'd9, 16'd9, 3'd0, 1'b0);
        #1;
        chk("mid_ptr0", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mid_rsp_w", 32'(rsp_w), 32'd42);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("mid_done", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
